hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
- Controller between the EX stage and the iterative unsigned divider `divu`.
- Accepts DIV/DIVU from EX and converts signed operands to magnitudes before driving the divider's start/busy handshake.
- Sign-corrects the divider's q/r and writes them to the architectural LO/HI registers.
- Owns MTHI/MTLO writes and the HI/LO read ports; stalls the pipeline while a divide is outstanding.

Parameters:
- WIDTH, 32, datapath width of operands, HI, LO.
- BUSY_WAIT_MAX, 4, cycles to wait for `div_busy` to rise after a start pulse before aborting.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  synchronous active-low reset.
- op_div  input  1  signed divide request (rs / rt).
- op_divu  input  1  unsigned divide request.
- op_mthi  input  1  write rs_val to HI.
- op_mtlo  input  1  write rs_val to LO.
- op_mf  input  1  MFHI/MFLO in EX needs HI/LO.
- rs_val  input  WIDTH  dividend / MT data.
- rt_val  input  WIDTH  divisor.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- stall  output  1  freeze EX and earlier stages.
- div_a  output  WIDTH  dividend magnitude to `divu`.
- div_b  output  WIDTH  divisor magnitude to `divu`.
- div_start  output  1  one-cycle start pulse to `divu`.
- div_q  input  WIDTH  `divu` quotient.
- div_r  input  WIDTH  `divu` remainder.
- div_busy  input  1  `divu` busy.
- div_zero_exc  output  1  divide-by-zero pulse (optional feature only).

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, hi=0, lo=0, div_a=0, div_b=0, div_start=0, stall=0, internal sign flags=0. Applies mid-operation; the divider result in flight is discarded.
- Request priority when several are asserted together: op_div > op_divu > op_mthi > op_mtlo. Only the highest-priority request is acted on.
- States: IDLE, START, WAIT_BUSY, RUN, FIX.
- IDLE:
  - op_div/op_divu with rt_val!=0: register div_a=|rs_val|, div_b=|rt_val| (unsigned passes through). Record neg_q = signed & (rs[31]^rt[31]) and neg_r = signed & rs[31]. Go to START. No stall in the accepting cycle.
  - Any divide with rt_val=0: no divider run. Next edge lo=all-ones, hi=rs_val. Stay IDLE.
  - op_mthi/op_mtlo: write at next edge.
  - op_mf: no stall; hi/lo are plain register outputs.
- START: div_start=1 for exactly this cycle. Go to WAIT_BUSY. div_a/div_b are held constant from START through RUN.
- WAIT_BUSY: when div_busy=1, go to RUN. If BUSY_WAIT_MAX cycles pass without busy, go to IDLE with hi/lo unchanged (abort).
- RUN: when div_busy=0, capture div_q/div_r into internal regs and go to FIX.
- FIX:
  - lo = neg_q ? -q : q; hi = neg_r ? -r : r (two's complement, WIDTH bits).
  - Go to IDLE. hi/lo are visible the cycle after FIX.
- Overflow 0x80000000 / -1: magnitudes 0x80000000 / 1 give lo=0x80000000, hi=0. No special case.
- stall = (state!=IDLE) & (op_div|op_divu|op_mthi|op_mtlo|op_mf). Stalled requests are re-presented by the pipeline and accepted in IDLE.
- Latency, accepting edge to lo/hi updated: 1 (START) + busy rise delay + divider run + 1 (FIX) + 1.
- Unrelated instructions never stall.

Optional Feature:
- Macro: HILO_DIVZERO_EXC_EN.
- Defined: a divide with rt_val=0 leaves hi/lo unchanged and pulses div_zero_exc=1 for one cycle, on the cycle after acceptance.
- Undefined: div_zero_exc is tied 0 and the all-ones/dividend write above applies.

Test Plan:
- divu rs=7, rt=2; bench divider models 33-cycle busy -> single div_start pulse; lo=3, hi=1 after FIX; stall only on later HI/LO ops during the run.
- div rs=-7 (0xFFFFFFF9), rt=2 -> div_a=7, div_b=2; lo=0xFFFFFFFD, hi=0xFFFFFFFF. div rs=7, rt=-2 -> lo=0xFFFFFFFD, hi=1.
- divu rs=0xFFFFFFFF, rt=2 -> lo=0x7FFFFFFF, hi=1. div rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu rs=55, rt=0 -> no div_start; lo=0xFFFFFFFF, hi=55 (macro off). With macro on: hi/lo unchanged and one-cycle div_zero_exc.
- mthi rs=0x1234 presented during RUN -> stall=1 until return to IDLE, then hi=0x1234 one cycle later. Divide result is written first, then overwritten by the MTHI.
- resetn=0 for one cycle during RUN -> next cycle state IDLE, hi=lo=0, stall=0; the later fall of div_busy causes no write.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: HI/LO register owner and sequencer for the iterative
// unsigned divider `divu`. Signed DIV operands are reduced to magnitudes
// before the run. The quotient and remainder are sign-corrected into LO/HI
// after the run.
// Optional build macro: HILO_DIVZERO_EXC_EN. When it is defined, a divide by
// zero raises a one-cycle div_zero_exc pulse and leaves HI/LO unchanged.
// When it is undefined, div_zero_exc is tied low and a divide by zero writes
// LO=all-ones and HI=dividend.
module hilo_div_ctrl #(
    parameter int WIDTH         = 32,
    parameter int BUSY_WAIT_MAX = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             op_div,
    input  logic             op_divu,
    input  logic             op_mthi,
    input  logic             op_mtlo,
    input  logic             op_mf,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic             div_start,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    input  logic             div_busy,
    output logic             div_zero_exc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FIX   = 3'd4;

    localparam int              CW        = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;
    localparam logic [CW-1:0]   WAIT_LAST = CW'(BUSY_WAIT_MAX - 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Two's-complement negation at full WIDTH. The most negative value maps to itself.
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return (~v) + ONE;
    endfunction

    // Magnitude of an operand. Operands of an unsigned request pass through unchanged.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? f_neg(v) : v;
    endfunction

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_div_a;
    logic [WIDTH-1:0] r_div_b;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [CW-1:0]    r_wait_cnt;

    logic             w_div_req;
    logic             w_signed;
    logic             w_rt_zero;
    logic             w_idle;

    // op_div outranks op_divu, so a request with both bits set is treated as signed.
    assign w_div_req = op_div | op_divu;
    assign w_signed  = op_div;
    assign w_rt_zero = (rt_val == '0);
    assign w_idle    = (r_state == S_IDLE);

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign div_start = (r_state == S_START);
    assign stall     = ~w_idle & (op_div | op_divu | op_mthi | op_mtlo | op_mf);

    // Divide sequencer: accepts the request, then walks the start/busy handshake and captures q/r.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_div_a    <= '0;
            r_div_b    <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_div_req && !w_rt_zero) begin
                        r_div_a <= f_mag(rs_val, w_signed);
                        r_div_b <= f_mag(rt_val, w_signed);
                        r_neg_q <= w_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        r_neg_r <= w_signed & rs_val[WIDTH-1];
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_busy) begin
                        r_state <= S_RUN;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!div_busy) begin
                        r_q     <= div_q;
                        r_r     <= div_r;
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Architectural HI/LO writes: sign-corrected divide results, divide-by-zero fill, MTHI/MTLO.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == S_FIX) begin
            r_lo <= r_neg_q ? f_neg(r_q) : r_q;
            r_hi <= r_neg_r ? f_neg(r_r) : r_r;
        end else if (w_idle) begin
            if (w_div_req) begin
                if (w_rt_zero) begin
`ifndef HILO_DIVZERO_EXC_EN
                    r_lo <= '1;
                    r_hi <= rs_val;
`endif
                end
            end else if (op_mthi) begin
                r_hi <= rs_val;
            end else if (op_mtlo) begin
                r_lo <= rs_val;
            end
        end
    end

`ifdef HILO_DIVZERO_EXC_EN
    logic r_zero_exc;

    // One-cycle exception pulse on the cycle after a divide-by-zero is accepted.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_zero_exc <= 1'b0;
        end else begin
            r_zero_exc <= w_idle & w_div_req & w_rt_zero;
        end
    end

    assign div_zero_exc = r_zero_exc;
`else
    assign div_zero_exc = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl. A behavioural divu model drives a 33-cycle busy
// window. The checks use a vector table, a result scoreboard and hand-written
// corner sequences.
module tb_hilo_div_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn  = 1'b0;
    logic         op_div  = 1'b0;
    logic         op_divu = 1'b0;
    logic         op_mthi = 1'b0;
    logic         op_mtlo = 1'b0;
    logic         op_mf   = 1'b0;
    logic [W-1:0] rs_val  = '0;
    logic [W-1:0] rt_val  = '0;
    logic [W-1:0] hi, lo, div_a, div_b;
    logic [W-1:0] div_q   = '0;
    logic [W-1:0] div_r   = '0;
    logic         div_busy = 1'b0;
    logic         stall, div_start, div_zero_exc;

    hilo_div_ctrl #(.WIDTH(W), .BUSY_WAIT_MAX(4)) dut (
        .clock(clk), .resetn(resetn),
        .op_div(op_div), .op_divu(op_divu), .op_mthi(op_mthi), .op_mtlo(op_mtlo), .op_mf(op_mf),
        .rs_val(rs_val), .rt_val(rt_val), .hi(hi), .lo(lo), .stall(stall),
        .div_a(div_a), .div_b(div_b), .div_start(div_start),
        .div_q(div_q), .div_r(div_r), .div_busy(div_busy), .div_zero_exc(div_zero_exc)
    );

    // divu model: busy rises on the edge that sees div_start and stays high for 33 cycles
    logic no_busy = 1'b0;
    int   m_cnt   = 0;
    int   starts  = 0;
    always @(posedge clk) begin
        if (div_start) starts <= starts + 1;
        if (div_start && !no_busy) begin
            div_busy <= 1'b1;
            m_cnt    <= 33;
            div_q    <= div_a / div_b;
            div_r    <= div_a % div_b;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) div_busy <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic         div, divu, mthi, mtlo;
        logic [W-1:0] rs, rt, a, b, lo, hi;
        logic         zero;
    } vec_t;

    typedef struct {
        logic [W-1:0] lo, hi;
    } res_t;

    res_t sb[$];
    vec_t vecs[11];

    task automatic clear_ops();
        op_div = 1'b0; op_divu = 1'b0; op_mthi = 1'b0; op_mtlo = 1'b0; op_mf = 1'b0;
    endtask

    // Called at a negedge with the DUT idle.
    task automatic run_vec(input vec_t v, input int idx);
        logic [W-1:0] plo, phi;
        res_t e;
        int   s0, n;
        plo = lo; phi = hi; s0 = starts;
        e.lo = v.lo; e.hi = v.hi;
`ifdef HILO_DIVZERO_EXC_EN
        if (v.zero) begin e.lo = plo; e.hi = phi; end
`endif
        sb.push_back(e);
        op_div = v.div; op_divu = v.divu; op_mthi = v.mthi; op_mtlo = v.mtlo;
        rs_val = v.rs; rt_val = v.rt;
        #1 chkb($sformatf("v%0d accept stall", idx), stall, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clear_ops();
        #1;
        if (v.zero) begin
            e = sb.pop_front();
            chk($sformatf("v%0d lo", idx), lo, e.lo);
            chk($sformatf("v%0d hi", idx), hi, e.hi);
`ifdef HILO_DIVZERO_EXC_EN
            chkb($sformatf("v%0d zero_exc pulse", idx), div_zero_exc, 1'b1);
`else
            chkb($sformatf("v%0d zero_exc", idx), div_zero_exc, 1'b0);
`endif
            @(negedge clk);
            #1 chkb($sformatf("v%0d zero_exc end", idx), div_zero_exc, 1'b0);
            chki($sformatf("v%0d start count", idx), starts - s0, 0);
        end else begin
            chkb($sformatf("v%0d div_start", idx), div_start, 1'b1);
            chk($sformatf("v%0d div_a", idx), div_a, v.a);
            chk($sformatf("v%0d div_b", idx), div_b, v.b);
            n = 0;
            while (!div_busy && n < 10) begin @(negedge clk); n++; end
            chkb($sformatf("v%0d busy rise", idx), div_busy, 1'b1);
            n = 0;
            while (div_busy && n < 60) begin @(negedge clk); n++; end
            chkb($sformatf("v%0d busy fall", idx), div_busy, 1'b0);
            @(negedge clk);
            #1 chk($sformatf("v%0d lo before FIX", idx), lo, plo);
            @(negedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d lo", idx), lo, e.lo);
            chk($sformatf("v%0d hi", idx), hi, e.hi);
            chki($sformatf("v%0d start count", idx), starts - s0, 1);
        end
    endtask

    initial begin
        int           n, s0;
        logic [W-1:0] plo, phi;

        //            div   divu  mthi  mtlo  rs            rt            a             b            lo            hi            zero
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd7,        32'd2,        32'd7,        32'd2,       32'd3,        32'd1,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        32'd7,        32'd2,       32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd7,        32'hFFFFFFFE, 32'd7,        32'd2,       32'hFFFFFFFD, 32'd1,        1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'd2,       32'h7FFFFFFF, 32'd1,        1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd1,       32'h80000000, 32'd0,        1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd55,       32'd0,        32'd0,        32'd0,       32'hFFFFFFFF, 32'd55,       1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFF9C, 32'd7,        32'd100,      32'd7,       32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        32'd7,        32'd2,       32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd20,       32'd3,        32'd20,       32'd3,       32'd6,        32'd2,        1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        32'd5,        32'd0,        32'd5,       32'd0,        32'd0,        1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd5,        32'd0,        32'd0,        32'd0,       32'hFFFFFFFF, 32'd5,        1'b1};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset div_a", div_a, 32'd0);
        chk("reset div_b", div_b, 32'd0);
        chkb("reset div_start", div_start, 1'b0);
        chkb("reset stall", stall, 1'b0);
        op_mf = 1'b1;
        #1 chkb("idle mf no stall", stall, 1'b0);
        op_mf = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // busy never rises: abort after the wait window, HI/LO untouched
        no_busy = 1'b1;
        plo = lo; phi = hi; s0 = starts;
        op_divu = 1'b1; rs_val = 32'd9; rt_val = 32'd2;
        @(posedge clk);
        @(negedge clk);
        clear_ops();
        op_mf = 1'b1;
        #1;
        n = 0;
        while (stall && n < 20) begin n++; @(negedge clk); #1; end
        chki("abort stall cycles", n, 5);
        chk("abort lo", lo, plo);
        chk("abort hi", hi, phi);
        chki("abort start count", starts - s0, 1);
        op_mf = 1'b0;
        no_busy = 1'b0;
        @(negedge clk);

        // MTHI arriving during a run: stalled until idle, divide result lands first
        op_divu = 1'b1; rs_val = 32'd7; rt_val = 32'd2;
        @(posedge clk);
        @(negedge clk);
        clear_ops();
        #1 chkb("unrelated no stall", stall, 1'b0);
        op_mthi = 1'b1; rs_val = 32'h1234;
        #1;
        n = 0;
        while (stall && n < 80) begin n++; @(negedge clk); #1; end
        chki("mthi stall cycles", n, 36);
        chk("div lo before mthi", lo, 32'd3);
        chk("div hi before mthi", hi, 32'd1);
        @(posedge clk);
        @(negedge clk);
        clear_ops();
        #1;
        chk("mthi hi", hi, 32'h1234);
        chk("mthi lo kept", lo, 32'd3);

        // MTHI outranks MTLO, then a lone MTLO
        op_mthi = 1'b1; op_mtlo = 1'b1; rs_val = 32'hABCD;
        @(posedge clk);
        @(negedge clk);
        clear_ops();
        #1;
        chk("prio hi", hi, 32'hABCD);
        chk("prio lo", lo, 32'd3);
        op_mtlo = 1'b1; rs_val = 32'h55;
        @(posedge clk);
        @(negedge clk);
        clear_ops();
        #1;
        chk("mtlo lo", lo, 32'h55);
        chk("mtlo hi", hi, 32'hABCD);

        // reset pulse during RUN: divider result in flight is dropped
        op_divu = 1'b1; rs_val = 32'd50; rt_val = 32'd3;
        @(posedge clk);
        @(negedge clk);
        clear_ops();
        n = 0;
        while (!div_busy && n < 10) begin @(negedge clk); n++; end
        chkb("rst-run busy rise", div_busy, 1'b1);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        op_mf = 1'b1;
        #1;
        chkb("rst-run stall", stall, 1'b0);
        chk("rst-run hi", hi, 32'd0);
        chk("rst-run lo", lo, 32'd0);
        op_mf = 1'b0;
        n = 0;
        while (div_busy && n < 60) begin @(negedge clk); n++; end
        chkb("rst-run busy fall", div_busy, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst-run lo after busy", lo, 32'd0);
        chk("rst-run hi after busy", hi, 32'd0);
        chki("scoreboard drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
